// File: rtl/keypad_calc_fsm.sv
// keypad_calc_fsm: keypad-driven two-operand decimal calculator sequencer
module keypad_calc_fsm #(
  parameter int DIGITS = 2,
  parameter int OP_W = 7,
  parameter int RES_W = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       key_in,
  input  logic             key_valid,
  output logic [1:0]       state,
  output logic [1:0]       mode_arith,
  output logic [OP_W-1:0]  operand_a,
  output logic [OP_W-1:0]  operand_b,
  output logic [RES_W-1:0] result,
  output logic             result_valid,
  output logic             key_ignored
);
  localparam int CW = $clog2(DIGITS + 1);
  typedef enum logic [1:0] {S_A, S_OP, S_B, S_RES} state_t;
  state_t st;
  logic [CW-1:0] cnt;
  logic is_dig, is_op, room;
  logic [OP_W-1:0] cur, dig;
  logic [OP_W+3:0] acc;
  logic signed [RES_W-1:0] ax, bx, res_calc;
  always_comb begin
    is_dig = key_in < 4'd10;
    is_op = key_in >= 4'd10 && key_in <= 4'd12;
    room = cnt < CW'(DIGITS);
    cur = st == S_A ? operand_a : operand_b;
    dig = OP_W'(key_in);
    acc = (OP_W+4)'(cur) * (OP_W+4)'(10) + (OP_W+4)'(key_in);
    ax = $signed(RES_W'(operand_a));
    bx = $signed(RES_W'(operand_b));
    res_calc = mode_arith == 2'd0 ? ax + bx : mode_arith == 2'd1 ? ax - bx : ax * bx;
  end
  assign state = st;
  always_ff @(posedge clk) begin
    if (rst || (key_valid && key_in == 4'd15)) begin
      st <= S_A;
      cnt <= '0;
      mode_arith <= '0;
      operand_a <= '0;
      operand_b <= '0;
      result <= '0;
      result_valid <= 1'b0;
      key_ignored <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      key_ignored <= 1'b0;
      if (key_valid) begin
        case (st)
          S_A: begin
            if (is_dig) begin
              if (room) begin
                operand_a <= acc[OP_W-1:0];
                cnt <= cnt + 1'b1;
              end else key_ignored <= 1'b1;
            end else if (is_op) begin
              mode_arith <= 2'(key_in - 4'd10);
              cnt <= '0;
              st <= S_OP;
            end else if (key_in == 4'd13) key_ignored <= 1'b1;
            else begin
              operand_a <= '0;
              cnt <= '0;
            end
          end
          S_OP: begin
            if (is_dig) begin
              operand_b <= dig;
              cnt <= CW'(1);
              st <= S_B;
            end else if (is_op) mode_arith <= 2'(key_in - 4'd10);
            else if (key_in == 4'd13) key_ignored <= 1'b1;
            else begin
              operand_b <= '0;
              cnt <= '0;
            end
          end
          S_B: begin
            if (is_dig) begin
              if (room) begin
                operand_b <= acc[OP_W-1:0];
                cnt <= cnt + 1'b1;
              end else key_ignored <= 1'b1;
            end else if (is_op) mode_arith <= 2'(key_in - 4'd10);
            else if (key_in == 4'd13) begin
              result <= res_calc;
              result_valid <= 1'b1;
              st <= S_RES;
            end else begin
              operand_b <= '0;
              cnt <= '0;
              st <= S_OP;
            end
          end
          default: begin
            if (is_dig) begin
              operand_a <= dig;
              operand_b <= '0;
              cnt <= CW'(1);
              st <= S_A;
            end else key_ignored <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_keypad_calc_fsm.sv
// tb_keypad_calc_fsm: directed self-checking bench for keypad_calc_fsm
module tb_keypad_calc_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] key_in = '0;
  logic key_valid = 1'b0;
  logic [1:0] state, mode_arith;
  logic [6:0] operand_a, operand_b;
  logic [14:0] result;
  logic result_valid, key_ignored;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  keypad_calc_fsm dut (
    .clk(clk),
    .rst(rst),
    .key_in(key_in),
    .key_valid(key_valid),
    .state(state),
    .mode_arith(mode_arith),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .result(result),
    .result_valid(result_valid),
    .key_ignored(key_ignored)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_in = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask
  task automatic idle();
    @(negedge clk);
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_mode"}, 32'(mode_arith), 0);
    chk({tag, "_a"}, 32'(operand_a), 0);
    chk({tag, "_b"}, 32'(operand_b), 0);
    chk({tag, "_res"}, 32'(result), 0);
    chk({tag, "_rv"}, 32'(result_valid), 0);
    chk({tag, "_ki"}, 32'(key_ignored), 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_all_zero("reset");
    press(4); press(2); press(10); press(1); press(7);
    chk("add_state_b", 32'(state), 2);
    press(13);
    chk("add_rv", 32'(result_valid), 1);
    chk("add_res", 32'(result), 59);
    chk("add_a", 32'(operand_a), 42);
    chk("add_b", 32'(operand_b), 17);
    chk("add_state", 32'(state), 3);
    idle();
    chk("add_rv_pulse", 32'(result_valid), 0);
    press(3);
    chk("res_dig_a", 32'(operand_a), 3);
    chk("res_dig_b", 32'(operand_b), 0);
    chk("res_dig_state", 32'(state), 0);
    chk("res_held", 32'(result), 59);
    press(11); press(8); press(13);
    chk("sub_mode", 32'(mode_arith), 1);
    chk("sub_res", 32'(result), 32'h7FFB);
    press(9); press(9);
    chk("a99_ki0", 32'(key_ignored), 0);
    press(9);
    chk("a99_ki", 32'(key_ignored), 1);
    chk("a99_a", 32'(operand_a), 99);
    idle();
    chk("a99_ki_pulse", 32'(key_ignored), 0);
    press(12); press(9); press(9); press(9);
    chk("b99_ki", 32'(key_ignored), 1);
    press(13);
    chk("mul_res", 32'(result), 9801);
    press(10);
    chk("res_op_ki", 32'(key_ignored), 1);
    press(13);
    chk("res_eq_ki", 32'(key_ignored), 1);
    chk("res_eq_rv", 32'(result_valid), 0);
    press(5); press(10); press(11); press(12);
    chk("op_last_mode", 32'(mode_arith), 2);
    chk("op_state", 32'(state), 1);
    press(13);
    chk("op_eq_ki", 32'(key_ignored), 1);
    press(3);
    chk("opb_state", 32'(state), 2);
    press(10);
    chk("b_op_mode", 32'(mode_arith), 0);
    chk("b_op_state", 32'(state), 2);
    press(13);
    chk("mode_res", 32'(result), 8);
    press(7); press(10); press(6); press(14);
    chk("ce_b", 32'(operand_b), 0);
    chk("ce_state", 32'(state), 1);
    chk("ce_a", 32'(operand_a), 7);
    press(2); press(13);
    chk("ce_res", 32'(result), 9);
    @(negedge clk);
    key_in = 4'd5;
    @(negedge clk);
    chk("novalid_a", 32'(operand_a), 7);
    chk("novalid_state", 32'(state), 3);
    press(15);
    chk_all_zero("ac");
    press(13);
    chk("a_eq_ki", 32'(key_ignored), 1);
    press(6); press(14);
    chk("a_ce", 32'(operand_a), 0);
    press(3); press(1);
    chk("a_after_ce", 32'(operand_a), 31);
    press(11); press(2);
    @(negedge clk);
    rst = 1'b1;
    key_in = 4'd5;
    key_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    key_valid = 1'b0;
    chk_all_zero("rst_mid");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
